// File: rtl/adder_tree_feeder_pkg.sv
// adder_tree_pkg: shared defaults and widths for the adder-tree operand feeder.
//   ADDER_WIDTH_DEF / LANES_DEF : default operand width and lanes per bundle
//   operand_t                   : one operand at the default width
//   LANE_IDX_W / COUNT_W        : lane index width and real-lane count width
//   lane_idx_w()                : index width for an arbitrary lane count
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEF = 28;
  localparam int LANES_DEF       = 8;
  localparam int LANE_IDX_W      = $clog2(LANES_DEF);
  localparam int COUNT_W         = LANE_IDX_W + 1;

  typedef logic [ADDER_WIDTH_DEF-1:0] operand_t;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/adder_tree_feeder_if.sv
// adder_tree_feeder_if: stream-in / bundle-out handshake bundle.
//   in_data/in_valid/in_last/in_ready : word stream into the feeder
//   out_lanes/out_valid/out_ready     : parallel bundle to the adder tree
//   out_count                         : real-lane count (ADDER_FEEDER_COUNT_EN only)
// modport slave = feeder side, master = producer/consumer side.
interface adder_tree_feeder_if #(
  parameter int ADDER_WIDTH = 28,
  parameter int LANES       = 8
) ();
  logic [ADDER_WIDTH-1:0]       in_data;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic [LANES*ADDER_WIDTH-1:0] out_lanes;
  logic                         out_valid;
  logic                         out_ready;
`ifdef ADDER_FEEDER_COUNT_EN
  logic [$clog2(LANES):0]       out_count;

  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_lanes, out_valid, out_count);
  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_lanes, out_valid, out_count);
`else
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_lanes, out_valid);
  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_lanes, out_valid);
`endif
endinterface

// File: rtl/adder_tree_feeder_lane_buf.sv
// adder_feeder_lane_buf: LANES-word collect buffer.
//   wr_en/wr_idx/wr_data : write one word into lane wr_idx
//   fill                 : with wr_en, zero every lane above wr_idx (frame close)
//   lanes_q              : stored bundle
//   lanes_nxt            : bundle as it will be after this cycle's write; lets the
//                          top load a completed bundle straight into its output
//                          register without waiting a cycle.
module adder_feeder_lane_buf
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int IW          = lane_idx_w(LANES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [IW-1:0]                     wr_idx,
  input  logic [ADDER_WIDTH-1:0]            wr_data,
  input  logic                              fill,
  output logic [LANES-1:0][ADDER_WIDTH-1:0] lanes_q,
  output logic [LANES-1:0][ADDER_WIDTH-1:0] lanes_nxt
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic                   sel;
    logic                   clr;
    logic [ADDER_WIDTH-1:0] word_q;

    assign sel          = wr_en && (wr_idx == IW'(k));
    assign clr          = wr_en && fill && (wr_idx < IW'(k));
    assign lanes_nxt[k] = sel ? wr_data : (clr ? '0 : word_q);
    assign lanes_q[k]   = word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) word_q <= '0;
      else        word_q <= lanes_nxt[k];
    end
  end

endmodule

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: packs a valid/ready stream of ADDER_WIDTH-bit words into
// LANES-wide bundles for adder-tree leaves. in_last closes a frame early and
// the remaining lanes are zero-padded.
//   clk, rst_n : clock, async active-low reset
//   bus        : adder_tree_feeder_if.slave (stream in, bundle out)
// Optional macro ADDER_FEEDER_COUNT_EN adds out_count (real lanes in bundle).
// Two stages: collect buffer (+ idx, HOLD state) and output register. A
// completed bundle goes straight to the output if it is free, else it is
// parked in the collect buffer (HOLD) and input stalls.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int LANES       = LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_tree_feeder_if.slave bus
);

  localparam int IW = lane_idx_w(LANES);
  localparam int CW = $clog2(LANES) + 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic                              rdy_q;
  logic [LANES-1:0][ADDER_WIDTH-1:0] out_q;
  logic                              out_vld_q;
  logic [LANES-1:0][ADDER_WIDTH-1:0] buf_q, buf_nxt;

  logic in_fire, out_free, at_end, complete, load_new, load_held;

  assign in_fire  = bus.in_valid && rdy_q;
  assign out_free = !out_vld_q || bus.out_ready;
  assign at_end   = (idx_q == IW'(LANES-1));
  assign complete = in_fire && (at_end || bus.in_last);

  adder_feeder_lane_buf #(
    .ADDER_WIDTH(ADDER_WIDTH),
    .LANES      (LANES),
    .IW         (IW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (in_fire),
    .wr_idx   (idx_q),
    .wr_data  (bus.in_data),
    .fill     (complete),
    .lanes_q  (buf_q),
    .lanes_nxt(buf_nxt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_new  = 1'b0;
    load_held = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_fire) idx_d = complete ? '0 : idx_q + IW'(1);
        if (complete) begin
          if (out_free) load_new = 1'b1;
          else          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_free) begin
          load_held = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // in_ready comes only from registered state: it drops as HOLD is entered and
  // reopens one cycle after HOLD is left, so out_ready never reaches in_ready
  // combinationally. It is also 0 through reset and opens on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= (state_q == COLLECT) && (state_d == COLLECT);
  end

  // Output register: lanes only change on a load, so they stay stable while
  // the consumer stalls; valid drops after a transfer with nothing to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (load_new) begin
      out_q     <= buf_nxt;
      out_vld_q <= 1'b1;
    end else if (load_held) begin
      out_q     <= buf_q;
      out_vld_q <= 1'b1;
    end else if (out_vld_q && bus.out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_lanes = out_q;
  assign bus.out_valid = out_vld_q;

`ifdef ADDER_FEEDER_COUNT_EN
  logic [CW-1:0] cnt_in, hold_cnt_q, out_cnt_q;

  assign cnt_in = CW'(idx_q) + CW'(1);

  // Count travels with the bundle: captured at completion for a held bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (complete)       hold_cnt_q <= cnt_in;
      if (load_new)       out_cnt_q  <= cnt_in;
      else if (load_held) out_cnt_q  <= hold_cnt_q;
    end
  end

  assign bus.out_count = out_cnt_q;
`endif

endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder: directed vectors with hand-computed bundles.
// Inputs driven 1 time unit after the rising edge, outputs sampled there or at
// the falling edge; accepted bundles are logged by a small monitor.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  localparam int W  = ADDER_WIDTH_DEF;
  localparam int L  = LANES_DEF;
  localparam int BW = W * L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_tree_feeder_if #(.ADDER_WIDTH(W), .LANES(L)) bus ();

  adder_tree_feeder #(.ADDER_WIDTH(W), .LANES(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [BW-1:0] got_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_lanes);
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Bundle with lane k = base+k for k < n, zero above.
  function automatic logic [BW-1:0] mk(input logic [W-1:0] base, input int n);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*W +: W] = base + W'(k);
    return v;
  endfunction

  // Offer one word, wait (bounded) for in_ready, return 1 unit after the
  // accepting edge so back-to-back calls stream one word per cycle.
  task automatic push(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] e;
    int c0;

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_lanes", bus.out_lanes, 0);
`ifdef ADDER_FEEDER_COUNT_EN
    chk("rst_out_count", bus.out_count, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", bus.in_ready, 1);

    // full bundle 1..8, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i), 1'b0);
    chk("full_valid", bus.out_valid, 1);
    chk("full_lanes", bus.out_lanes, mk(W'(1), 8));
`ifdef ADDER_FEEDER_COUNT_EN
    chk("full_count", bus.out_count, 8);
`endif
    @(posedge clk); #1;
    chk("full_valid_1cyc", bus.out_valid, 0);

    // short frame of two words
    push(28'hAAAAAAA, 1'b0);
    push(28'h5555555, 1'b1);
    e = '0;
    e[0 +: W] = 28'hAAAAAAA;
    e[W +: W] = 28'h5555555;
    chk("short_valid", bus.out_valid, 1);
    chk("short_lanes", bus.out_lanes, e);
`ifdef ADDER_FEEDER_COUNT_EN
    chk("short_count", bus.out_count, 2);
`endif
    @(posedge clk); #1;

    // stalled consumer: bundle 1 held in output, bundle 2 parked in HOLD
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(W'(28'h100 + i), 1'b0);
    chk("hold_in_ready_low", bus.in_ready, 0);
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_b1_lanes", bus.out_lanes, mk(W'(28'h100), 8));
    repeat (3) @(posedge clk); #1;
    chk("hold_b1_stable", bus.out_lanes, mk(W'(28'h100), 8));
    chk("hold_still_blocked", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rec_valid", bus.out_valid, 1);
    chk("rec_b2_lanes", bus.out_lanes, mk(W'(28'h108), 8));
    chk("rec_in_ready_lag", bus.in_ready, 0);
`ifdef ADDER_FEEDER_COUNT_EN
    chk("rec_b2_count", bus.out_count, 8);
`endif
    @(posedge clk); #1;
    chk("rec_in_ready_up", bus.in_ready, 1);
    chk("rec_valid_drop", bus.out_valid, 0);

    // 32 words continuous, four bundles, no input gaps
    got_q.delete();
    c0 = cyc;
    for (int i = 0; i < 32; i++) push(W'(28'h200 + i), 1'b0);
    chk("stream_cycles", cyc - c0, 32);
    @(posedge clk); #1;
    chk("stream_bundles", got_q.size(), 4);
    for (int b = 0; b < 4 && b < got_q.size(); b++)
      chk($sformatf("stream_b%0d", b), got_q[b], mk(W'(28'h200 + 8*b), 8));

    // reset mid-frame
    for (int i = 0; i < 3; i++) push(W'(28'h300 + i), 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_lanes", bus.out_lanes, 0);
`ifdef ADDER_FEEDER_COUNT_EN
    chk("mid_rst_count", bus.out_count, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(W'(28'h400 + i), 1'b0);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_lanes", bus.out_lanes, mk(W'(28'h400), 8));
    @(posedge clk); #1;

    // single all-ones word closing a frame on lane 0
    push(28'hFFFFFFF, 1'b1);
    e = '0;
    e[0 +: W] = 28'hFFFFFFF;
    chk("single_valid", bus.out_valid, 1);
    chk("single_lanes", bus.out_lanes, e);
`ifdef ADDER_FEEDER_COUNT_EN
    chk("single_count", bus.out_count, 1);
`endif
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
